// File: rtl/traffic_phase_sched.sv
// Single-intersection signal phase controller: grants green to one approach at a
// time through GREEN -> YELLOW -> ALL_RED with density-scaled green and preemption.
module traffic_phase_sched #(
  parameter int N_DIR      = 5,
  parameter int CNT_W      = 14,
  parameter int PRI_W      = 4,
  parameter int PRIO_WT    = 256,
  parameter int GREEN_MIN  = 20,
  parameter int GREEN_MAX  = 60,
  parameter int YELLOW_T   = 5,
  parameter int ALLRED_T   = 2,
  parameter int DENS_SHIFT = 4,
  parameter int AGE_W      = 8,
  parameter int STARVE_LIM = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_DIR*CNT_W-1:0] density,
  input  logic                   density_vld,
  input  logic [N_DIR*PRI_W-1:0] prio,
  input  logic [N_DIR*PRI_W-1:0] emerg,
  output logic [N_DIR*2-1:0]     light,
  output logic [N_DIR-1:0]       active,
  output logic [1:0]             state,
  output logic                   preempt
);

  localparam logic [1:0] ST_ALL_RED = 2'b00;
  localparam logic [1:0] ST_GREEN   = 2'b01;
  localparam logic [1:0] ST_YELLOW  = 2'b10;

  localparam int SC_W  = CNT_W + 1;
  localparam int RAW_W = CNT_W + PRI_W + $clog2(PRIO_WT + 1) + 1;
  localparam int TMR_W = $clog2(GREEN_MAX + YELLOW_T + ALLRED_T + 1);
  localparam int IDX_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  localparam logic [TMR_W-1:0] T_ALLRED = TMR_W'(ALLRED_T);
  localparam logic [TMR_W-1:0] T_YELLOW = TMR_W'(YELLOW_T);
  localparam logic [TMR_W-1:0] T_GMIN   = TMR_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] EXT_CAP  = CNT_W'(GREEN_MAX - GREEN_MIN);
  localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(STARVE_LIM);

  logic [1:0]       st;
  logic [TMR_W-1:0] timer;
  logic [N_DIR-1:0] act;
  logic             preempt_q;
  logic [IDX_W-1:0] rr;
  logic [CNT_W-1:0] dens_q [N_DIR];
  logic [AGE_W-1:0] age    [N_DIR];

  logic [PRI_W-1:0] prio_a  [N_DIR];
  logic [PRI_W-1:0] emerg_a [N_DIR];
  logic [SC_W-1:0]  score   [N_DIR];

  // density + prio*PRIO_WT, clamped to an all-ones CNT_W+1 bit value
  function automatic logic [SC_W-1:0] sat_score(input logic [CNT_W-1:0] d,
                                                input logic [PRI_W-1:0] p);
    logic [RAW_W-1:0] raw;
    raw = RAW_W'(d) + RAW_W'(p) * RAW_W'(PRIO_WT);
    if (raw > RAW_W'({SC_W{1'b1}})) return {SC_W{1'b1}};
    return raw[SC_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < N_DIR; i++) begin
      prio_a[i]  = prio[i*PRI_W +: PRI_W];
      emerg_a[i] = emerg[i*PRI_W +: PRI_W];
      score[i]   = sat_score(dens_q[i], prio_a[i]);
    end
  end

  // Winner selection: emergency level, then starvation, then score with round-robin ties
  logic             e_any, s_any, sel_any;
  logic [PRI_W-1:0] e_best;
  logic [IDX_W-1:0] e_idx, s_idx, b_idx, sel_idx;
  logic [SC_W-1:0]  b_best;
  int               j;

  always_comb begin
    e_best = '0;
    e_idx  = '0;
    s_any  = 1'b0;
    s_idx  = '0;
    b_best = '0;
    b_idx  = rr;
    j      = 0;
    for (int i = 0; i < N_DIR; i++) begin
      if (emerg_a[i] > e_best) begin
        e_best = emerg_a[i];
        e_idx  = IDX_W'(i);
      end
    end
    for (int i = N_DIR - 1; i >= 0; i--) begin
      if (age[i] == AGE_LIM) begin
        s_any = 1'b1;
        s_idx = IDX_W'(i);
      end
    end
    for (int k = 0; k < N_DIR; k++) begin
      j = (int'(rr) + k) % N_DIR;
      if (score[j] > b_best) begin
        b_best = score[j];
        b_idx  = IDX_W'(j);
      end
    end
    e_any   = (e_best != '0);
    sel_any = e_any || s_any || (b_best != '0);
    sel_idx = e_any ? e_idx : (s_any ? s_idx : b_idx);
  end

  logic [CNT_W-1:0] ext;
  logic [TMR_W-1:0] green_load;
  logic [N_DIR-1:0] sel_oh;

  always_comb begin
    ext = dens_q[sel_idx] >> DENS_SHIFT;
    if (ext > EXT_CAP) ext = EXT_CAP;
    green_load = T_GMIN + TMR_W'(ext);
    sel_oh     = N_DIR'(1) << sel_idx;
  end

  // Emergency level on the current approach vs. any other approach
  logic [PRI_W-1:0] act_emerg;
  logic             oth_emerg;

  always_comb begin
    act_emerg = '0;
    oth_emerg = 1'b0;
    for (int i = 0; i < N_DIR; i++) begin
      if (act[i]) act_emerg = act_emerg | emerg_a[i];
      else if (emerg_a[i] != '0) oth_emerg = 1'b1;
    end
  end

  // density_vld is a plain strobe: density is captured on every edge where it is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= ST_ALL_RED;
      timer     <= T_ALLRED;
      act       <= '0;
      preempt_q <= 1'b0;
      rr        <= '0;
      for (int i = 0; i < N_DIR; i++) begin
        dens_q[i] <= '0;
        age[i]    <= '0;
      end
    end else begin
      preempt_q <= 1'b0;
      if (density_vld) begin
        for (int i = 0; i < N_DIR; i++) dens_q[i] <= density[i*CNT_W +: CNT_W];
      end
      for (int i = 0; i < N_DIR; i++) begin
        if (!act[i] && (dens_q[i] != '0 || prio_a[i] != '0) && age[i] != AGE_LIM)
          age[i] <= age[i] + 1'b1;
      end
      case (st)
        ST_ALL_RED: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (sel_any) begin
            st           <= ST_GREEN;
            act          <= sel_oh;
            timer        <= green_load;
            age[sel_idx] <= '0;
            rr           <= (sel_idx == IDX_W'(N_DIR - 1)) ? '0 : sel_idx + 1'b1;
          end
        end
        ST_GREEN: begin
          if (oth_emerg && act_emerg == '0) begin
            st        <= ST_YELLOW;
            timer     <= T_YELLOW;
            preempt_q <= 1'b1;
          end else if (act_emerg != '0) begin
            timer <= timer;
          end else if (timer == '0) begin
            st    <= ST_YELLOW;
            timer <= T_YELLOW;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_YELLOW: begin
          if (timer == '0) begin
            st    <= ST_ALL_RED;
            act   <= '0;
            timer <= T_ALLRED;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          st    <= ST_ALL_RED;
          act   <= '0;
          timer <= T_ALLRED;
        end
      endcase
    end
  end

  // Lights follow active, so a non-active approach can never show anything but red
  always_comb begin
    for (int i = 0; i < N_DIR; i++) begin
      if (!act[i])              light[i*2 +: 2] = 2'b00;
      else if (st == ST_GREEN)  light[i*2 +: 2] = 2'b10;
      else if (st == ST_YELLOW) light[i*2 +: 2] = 2'b01;
      else                      light[i*2 +: 2] = 2'b00;
    end
  end

  assign active  = act;
  assign state   = st;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched: a table of single-grant vectors plus
// hand-written sequences for reset, rotation, preemption and starvation.
module tb_traffic_phase_sched;

  localparam int N     = 5;
  localparam int CNT_W = 14;
  localparam int PRI_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N*CNT_W-1:0] density = '0;
  logic               density_vld = 1'b0;
  logic [N*PRI_W-1:0] prio = '0;
  logic [N*PRI_W-1:0] emerg = '0;
  logic [N*2-1:0]     light;
  logic [N-1:0]       active;
  logic [1:0]         state;
  logic               preempt;

  traffic_phase_sched dut (
    .clk(clk), .rst_n(rst_n), .density(density), .density_vld(density_vld),
    .prio(prio), .emerg(emerg), .light(light), .active(active),
    .state(state), .preempt(preempt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act_v, act_v, exp_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    density_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    density = '0;
    density_vld = 1'b0;
    prio = '0;
    emerg = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_green(output int n);
    n = 0;
    while (state != 2'b01 && n < 400) begin
      step();
      n++;
    end
  endtask

  function automatic logic [N*CNT_W-1:0] pd(input int a0, input int a1, input int a2,
                                            input int a3, input int a4);
    return {14'(a4), 14'(a3), 14'(a2), 14'(a1), 14'(a0)};
  endfunction

  function automatic logic [N*PRI_W-1:0] pp(input int a0, input int a1, input int a2,
                                            input int a3, input int a4);
    return {4'(a4), 4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  function automatic logic [N*2-1:0] green_light(input int w);
    logic [N*2-1:0] l;
    l = '0;
    l[2*w +: 2] = 2'b10;
    return l;
  endfunction

  typedef struct {
    logic [N*CNT_W-1:0] dens;
    logic [N*PRI_W-1:0] pr;
    logic [N*PRI_W-1:0] em;
    int                 exp_w;
    int                 exp_green;  // 0: green held by emergency, length not measured
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n, g, y, r, g0;
  logic found;
  logic [N-1:0] grants [6];
  logic [1:0] prev;
  int bad;

  initial begin
    vecs[0]  = '{pd(0, 0, 320, 0, 0),   pp(0, 0, 0, 0, 0), pp(0, 0, 0, 0, 0), 2, 41};
    vecs[1]  = '{pd(500, 0, 0, 0, 0),   pp(0, 0, 0, 2, 0), pp(0, 0, 0, 0, 0), 3, 21};
    vecs[2]  = '{pd(100, 100, 100, 100, 100), pp(0, 0, 0, 0, 0), pp(0, 0, 0, 0, 0), 0, 27};
    vecs[3]  = '{pd(0, 0, 0, 0, 2000),  pp(0, 0, 0, 0, 0), pp(0, 0, 0, 0, 0), 4, 61};
    vecs[4]  = '{pd(0, 16, 0, 16, 0),   pp(0, 0, 0, 0, 0), pp(0, 0, 0, 0, 0), 1, 22};
    vecs[5]  = '{pd(0, 0, 0, 0, 0),     pp(0, 0, 1, 0, 1), pp(0, 0, 0, 0, 0), 2, 21};
    vecs[6]  = '{pd(0, 0, 0, 15, 0),    pp(0, 0, 0, 0, 0), pp(0, 0, 0, 0, 0), 3, 21};
    vecs[7]  = '{pd(0, 0, 16383, 0, 0), pp(1, 0, 0, 0, 0), pp(0, 0, 0, 0, 0), 2, 61};
    vecs[8]  = '{pd(0, 0, 0, 0, 639),   pp(0, 0, 0, 0, 0), pp(0, 0, 0, 0, 0), 4, 60};
    vecs[9]  = '{pd(1000, 0, 0, 0, 0),  pp(0, 0, 0, 0, 0), pp(0, 0, 3, 0, 9), 4, 0};
    vecs[10] = '{pd(0, 0, 0, 0, 0),     pp(0, 0, 0, 0, 0), pp(0, 5, 0, 5, 0), 1, 0};

    // Reset state and idle behaviour with nothing to serve
    do_reset();
    check("rst_state", 32'(state), 32'(2'b00));
    check("rst_light", 32'(light), 32'(0));
    check("rst_active", 32'(active), 32'(0));
    check("rst_preempt", 32'(preempt), 32'(0));
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (state != 2'b00 || light != '0 || active != '0) bad++;
    end
    check("idle_all_red_cycles", 32'(bad), 32'(0));

    // Table-driven single grants
    for (int i = 0; i < NV; i++) begin
      do_reset();
      density = vecs[i].dens;
      prio = vecs[i].pr;
      emerg = vecs[i].em;
      density_vld = 1'b1;
      wait_green(n);
      check($sformatf("v%0d_red_wait", i), 32'(n), 32'(3));
      check($sformatf("v%0d_active", i), 32'(active), 32'(1 << vecs[i].exp_w));
      check($sformatf("v%0d_light", i), 32'(light), 32'(green_light(vecs[i].exp_w)));
      if (vecs[i].exp_green != 0) begin
        g = 0;
        while (state == 2'b01 && g < 300) begin
          g++;
          step();
        end
        check($sformatf("v%0d_green_len", i), 32'(g), 32'(vecs[i].exp_green));
        y = 0;
        while (state == 2'b10 && y < 20) begin
          y++;
          step();
        end
        check($sformatf("v%0d_yellow_len", i), 32'(y), 32'(6));
      end
    end

    // Reset in the middle of a green; timer must reload the all-red clearance
    do_reset();
    density = pd(0, 0, 320, 0, 0);
    density_vld = 1'b1;
    wait_green(n);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    check("midrst_state", 32'(state), 32'(2'b00));
    check("midrst_active", 32'(active), 32'(0));
    check("midrst_light", 32'(light), 32'(0));
    rst_n = 1'b1;
    density_vld = 1'b1;
    wait_green(n);
    check("midrst_red_wait", 32'(n), 32'(3));
    check("midrst_active_after", 32'(active), 32'(5'b00100));

    // Equal densities rotate round-robin
    do_reset();
    density = pd(100, 100, 100, 100, 100);
    density_vld = 1'b1;
    prev = state;
    g = 0;
    for (int c = 0; c < 300 && g < 6; c++) begin
      step();
      if (state == 2'b01 && prev != 2'b01) begin
        grants[g] = active;
        g++;
      end
      prev = state;
    end
    check("rr_grant_count", 32'(g), 32'(6));
    for (int k = 0; k < 6; k++) check($sformatf("rr_grant%0d", k), 32'(grants[k]), 32'(1 << (k % 5)));

    // Emergency preemption of a running green, then held green on the emergency approach
    do_reset();
    density = pd(0, 100, 0, 0, 0);
    density_vld = 1'b1;
    wait_green(n);
    check("emg_first_active", 32'(active), 32'(5'b00010));
    repeat (4) step();
    emerg = pp(0, 0, 0, 0, 8);
    step();
    check("emg_cut_state", 32'(state), 32'(2'b10));
    check("emg_cut_preempt", 32'(preempt), 32'(1));
    check("emg_cut_light", 32'(light), 32'(10'b00_00_00_01_00));
    y = 0;
    while (state == 2'b10 && y < 20) begin
      if (y == 1) check("emg_preempt_pulse_end", 32'(preempt), 32'(0));
      y++;
      step();
    end
    check("emg_yellow_len", 32'(y), 32'(6));
    r = 0;
    while (state == 2'b00 && r < 20) begin
      r++;
      step();
    end
    check("emg_red_len", 32'(r), 32'(3));
    check("emg_winner", 32'(active), 32'(5'b10000));
    repeat (80) step();
    check("emg_hold_state", 32'(state), 32'(2'b01));
    check("emg_hold_active", 32'(active), 32'(5'b10000));
    emerg = '0;
    g = 0;
    while (state == 2'b01 && g < 100) begin
      g++;
      step();
    end
    check("emg_release_green_len", 32'(g), 32'(21));

    // Starvation: low-density approach 1 is served once its wait count saturates
    do_reset();
    density = pd(4000, 10, 0, 0, 0);
    density_vld = 1'b1;
    prev = state;
    g0 = 0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      step();
      if (state == 2'b01 && prev != 2'b01) begin
        if (active == 5'b00010) found = 1'b1;
        else if (active == 5'b00001) g0++;
      end
      prev = state;
    end
    check("starve_found", 32'(found), 32'(1));
    check("starve_grants_before", 32'(g0), 32'(3));
    g = 0;
    while (state == 2'b01 && g < 100) begin
      g++;
      step();
    end
    check("starve_green_len", 32'(g), 32'(21));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
